// File: rtl/spi_frame_arbiter_if.sv
// Command bus between the requesters and the arbiter, plus the byte-stream
// link to the shared SPI byte master.
interface spi_frame_arbiter_if #(
    parameter int N_REQ      = 2,
    parameter int DATA_BYTES = 2
);
    logic [N_REQ-1:0]              req;
    logic [N_REQ-1:0]              rd;
    logic [7*N_REQ-1:0]            addr;
    logic [8*DATA_BYTES*N_REQ-1:0] wdata;
    logic [N_REQ-1:0]              ack;
    logic [N_REQ-1:0]              done;
    logic                          err;
    logic [8*DATA_BYTES-1:0]       rdata;
    logic                          busy;
    logic [7:0]                    master_data;
    logic                          master_empty;
    logic                          master_rdreq;
    logic [7:0]                    miso_reg;
    logic                          slave_wrreq;

    // slave: the arbiter; master: the requesters together with the SPI byte engine
    modport slave (
        input  req, rd, addr, wdata, master_rdreq, miso_reg, slave_wrreq,
        output ack, done, err, rdata, busy, master_data, master_empty
    );
    modport master (
        output req, rd, addr, wdata, master_rdreq, miso_reg, slave_wrreq,
        input  ack, done, err, rdata, busy, master_data, master_empty
    );
endinterface

// File: rtl/spi_frame_arbiter.sv
// Round-robin arbiter that serialises one requester command at a time into an
// SPI frame (command byte + DATA_BYTES data bytes) and returns read data.
module spi_frame_arbiter #(
    parameter int N_REQ      = 2,
    parameter int DATA_BYTES = 2,
    parameter int TIMEOUT    = 1023
) (
    input logic                sys_clk,
    input logic                n_rst,
    spi_frame_arbiter_if.slave bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(DATA_BYTES + 2);
    localparam int DW = 8 * DATA_BYTES;
    localparam int FW = DW + 8;
    localparam logic [CW-1:0] LAST_TX = CW'(DATA_BYTES);
    localparam logic [CW-1:0] RX_FULL = CW'(DATA_BYTES + 1);
    localparam logic [9:0]    TMO     = 10'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_RX, DONE} state_t;

    state_t           state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    g_lat;
    logic [IW-1:0]    gnt_idx;
    logic             gnt_found;
    int unsigned      cand;
    logic [N_REQ-1:0] ack_c;
    logic             rd_lat;
    logic [6:0]       addr_lat;
    logic [DW-1:0]    wdata_lat;
    logic [DW-1:0]    wr_bytes;
    logic [FW-1:0]    frame;
    logic [CW-1:0]    tx_cnt;
    logic [CW-1:0]    rx_cnt;
    logic [9:0]       timer;
    logic [DW-1:0]    rx_buf;
    logic [DW-1:0]    rdata_q;
    logic [N_REQ-1:0] done_q;
    logic             err_q;
    logic             busy_q;
    logic             empty_q;

    // First requesting index after the last grant, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = (32'(ptr) + i) % N_REQ;
            if (!gnt_found && bus.req[IW'(cand)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IW'(cand);
            end
        end
    end

    // Grant is visible in the same IDLE cycle the request is seen.
    always_comb begin
        ack_c = '0;
        if (state == IDLE && gnt_found && n_rst)
            ack_c[gnt_idx] = 1'b1;
    end

    assign wr_bytes         = rd_lat ? '0 : wdata_lat;
    assign bus.ack          = ack_c;
    assign bus.busy         = busy_q | (|ack_c);
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.rdata        = rdata_q;
    assign bus.master_data  = frame[FW-1 -: 8];
    assign bus.master_empty = empty_q;

    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            ptr       <= IW'(N_REQ - 1);
            g_lat     <= '0;
            rd_lat    <= 1'b0;
            addr_lat  <= '0;
            wdata_lat <= '0;
            frame     <= '0;
            tx_cnt    <= '0;
            rx_cnt    <= '0;
            timer     <= '0;
            rx_buf    <= '0;
            rdata_q   <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            empty_q   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        ptr       <= gnt_idx;
                        g_lat     <= gnt_idx;
                        rd_lat    <= bus.rd[gnt_idx];
                        addr_lat  <= bus.addr[7*32'(gnt_idx) +: 7];
                        wdata_lat <= bus.wdata[DW*32'(gnt_idx) +: DW];
                        busy_q    <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    frame   <= {rd_lat, addr_lat, wr_bytes};
                    tx_cnt  <= '0;
                    rx_cnt  <= '0;
                    timer   <= '0;
                    empty_q <= 1'b0;
                    state   <= SEND;
                end
                SEND, WAIT_RX: begin
                    if (state == SEND && bus.master_rdreq) begin
                        frame  <= frame << 8;
                        tx_cnt <= tx_cnt + 1'b1;
                        if (tx_cnt == LAST_TX) begin
                            empty_q <= 1'b1;
                            state   <= WAIT_RX;
                        end
                    end
                    // Received byte k lands in slot DATA_BYTES-k; byte 0 is dropped.
                    if (bus.slave_wrreq && rx_cnt != RX_FULL) begin
                        rx_cnt <= rx_cnt + 1'b1;
                        for (int unsigned k = 1; k <= DATA_BYTES; k++)
                            if (rx_cnt == CW'(k))
                                rx_buf[8*(DATA_BYTES-k) +: 8] <= bus.miso_reg;
                    end
                    if (bus.master_rdreq || bus.slave_wrreq)
                        timer <= '0;
                    else
                        timer <= timer + 1'b1;
                    if (timer == TMO) begin
                        empty_q <= 1'b1;
                        done_q  <= N_REQ'(1) << g_lat;
                        err_q   <= 1'b1;
                        state   <= DONE;
                    end else if (state == WAIT_RX && rx_cnt == RX_FULL) begin
                        done_q <= N_REQ'(1) << g_lat;
                        err_q  <= 1'b0;
                        if (rd_lat)
                            rdata_q <= rx_buf;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= '0;
                    err_q  <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_frame_arbiter.sv
// Directed bench for spi_frame_arbiter: the bench plays requesters and SPI byte
// master, with expected bytes and completions queued at grant time.
module tb_spi_frame_arbiter;
    localparam int N_REQ      = 2;
    localparam int DATA_BYTES = 2;
    localparam int TIMEOUT    = 1023;

    logic sys_clk = 1'b0;
    logic n_rst   = 1'b0;
    always #5 sys_clk = ~sys_clk;

    spi_frame_arbiter_if #(.N_REQ(N_REQ), .DATA_BYTES(DATA_BYTES)) bus ();

    spi_frame_arbiter #(
        .N_REQ(N_REQ),
        .DATA_BYTES(DATA_BYTES),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .sys_clk(sys_clk),
        .n_rst(n_rst),
        .bus(bus)
    );

    typedef struct {
        int          idx;
        logic        err;
        logic [15:0] rdata;
    } done_rec_t;

    logic [7:0]  exp_tx_q[$];
    logic [7:0]  miso_q[$];
    done_rec_t   exp_done_q[$];
    logic [15:0] model_rdata;
    logic        rd_v   [N_REQ];
    logic [6:0]  addr_v [N_REQ];
    logic [15:0] wd_v   [N_REQ];

    int checks        = 0;
    int failures      = 0;
    int done_pulses   = 0;
    int overlap_cycles = 0;

    always @(negedge sys_clk) begin
        if (bus.done != '0) done_pulses++;
        if (bus.done != '0 && bus.ack != '0) overlap_cycles++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_cmd(input int idx, input logic rdf, input logic [6:0] a, input logic [15:0] wd);
        rd_v[idx]   = rdf;
        addr_v[idx] = a;
        wd_v[idx]   = wd;
        bus.rd[idx]              = rdf;
        bus.addr[7*idx +: 7]     = a;
        bus.wdata[16*idx +: 16]  = wd;
    endtask

    // mode 0: normal completion, 1: timeout, 2: aborted by reset (no done)
    task automatic push_cmd(input int idx, input logic [7:0] m0, input logic [7:0] m1,
                            input logic [7:0] m2, input int mode);
        exp_tx_q.push_back({rd_v[idx], addr_v[idx]});
        exp_tx_q.push_back(rd_v[idx] ? 8'h00 : wd_v[idx][15:8]);
        exp_tx_q.push_back(rd_v[idx] ? 8'h00 : wd_v[idx][7:0]);
        miso_q.push_back(m0);
        miso_q.push_back(m1);
        miso_q.push_back(m2);
        if (mode == 0 && rd_v[idx]) model_rdata = {m1, m2};
        if (mode == 0) exp_done_q.push_back('{idx: idx, err: 1'b0, rdata: model_rdata});
        if (mode == 1) exp_done_q.push_back('{idx: idx, err: 1'b1, rdata: model_rdata});
    endtask

    task automatic grant(input int idx, input logic [7:0] m0, input logic [7:0] m1,
                         input logic [7:0] m2, input int mode);
        int n;
        n = 0;
        #1;
        while (bus.ack == '0 && n < 20) begin
            step();
            #1;
            n++;
        end
        chk("ack_wait", 32'(n < 20), 32'd1);
        chk("ack_vec", 32'(bus.ack), 32'(1) << idx);
        chk("busy_at_ack", 32'(bus.busy), 32'd1);
        push_cmd(idx, m0, m1, m2, mode);
        step();
        chk("ack_pulse", 32'(bus.ack), 32'd0);
        chk("load_empty", 32'(bus.master_empty), 32'd1);
        step();
        chk("send_empty", 32'(bus.master_empty), 32'd0);
    endtask

    task automatic serve(input int nbytes);
        for (int k = 0; k < nbytes; k++) begin
            logic [7:0] eb;
            logic [7:0] mb;
            int n;
            n = 0;
            while (bus.master_empty && n < 20) begin
                step();
                n++;
            end
            chk("tx_ready", 32'(n < 20), 32'd1);
            eb = exp_tx_q.pop_front();
            mb = miso_q.pop_front();
            chk("tx_byte", 32'(bus.master_data), 32'(eb));
            step();
            chk("tx_hold", 32'(bus.master_data), 32'(eb));
            bus.master_rdreq = 1'b1;
            step();
            bus.master_rdreq = 1'b0;
            if (k == DATA_BYTES) chk("empty_last", 32'(bus.master_empty), 32'd1);
            else                 chk("empty_mid", 32'(bus.master_empty), 32'd0);
            step();
            bus.miso_reg    = mb;
            bus.slave_wrreq = 1'b1;
            step();
            bus.slave_wrreq = 1'b0;
        end
    endtask

    task automatic finish_done(input int budget, output int n);
        done_rec_t r;
        n = 0;
        while (bus.done == '0 && n < budget) begin
            step();
            n++;
        end
        chk("done_wait", 32'(n < budget), 32'd1);
        r = exp_done_q.pop_front();
        chk("done_vec", 32'(bus.done), 32'(1) << r.idx);
        chk("done_err", 32'(bus.err), 32'(r.err));
        chk("done_rdata", 32'(bus.rdata), 32'(r.rdata));
        chk("empty_at_done", 32'(bus.master_empty), 32'd1);
        step();
        chk("done_pulse", 32'(bus.done), 32'd0);
    endtask

    initial begin
        logic [7:0] m0, m1, m2;
        int n;
        int dp;

        bus.req          = '0;
        bus.rd           = '0;
        bus.addr         = '0;
        bus.wdata        = '0;
        bus.master_rdreq = 1'b0;
        bus.miso_reg     = '0;
        bus.slave_wrreq  = 1'b0;
        model_rdata      = '0;
        set_cmd(0, 1'b0, 7'h15, 16'hA55A);
        set_cmd(1, 1'b1, 7'h03, 16'h0000);
        bus.req = 2'b11;

        // Reset values, with both requests already asserted
        repeat (3) step();
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_mdata", 32'(bus.master_data), 32'd0);
        chk("rst_empty", 32'(bus.master_empty), 32'd1);
        n_rst = 1'b1;

        // Round-robin with both requests held: write by 0, read by 1, alternating
        for (int f = 0; f < 4; f++) begin
            case (f)
                0: begin m0 = 8'h01; m1 = 8'h02; m2 = 8'h03; end
                1: begin m0 = 8'h5C; m1 = 8'hC3; m2 = 8'h7E; end
                2: begin m0 = 8'h99; m1 = 8'h98; m2 = 8'h97; end
                default: begin m0 = 8'h00; m1 = 8'h5A; m2 = 8'hA5; end
            endcase
            grant(f % 2, m0, m1, m2, 0);
            serve(3);
            finish_done(20, n);
            chk("done_latency", 32'(n), 32'd1);
        end
        bus.req = '0;
        step();
        chk("rr_no_overlap", 32'(overlap_cycles), 32'd0);
        chk("rr_busy_idle", 32'(bus.busy), 32'd0);
        chk("rr_rdata_hold", 32'(bus.rdata), 32'h5AA5);

        // Spurious strobes in IDLE
        dp = done_pulses;
        for (int i = 0; i < 3; i++) begin
            bus.miso_reg     = 8'hFF;
            bus.slave_wrreq  = 1'b1;
            bus.master_rdreq = 1'b1;
            step();
            bus.slave_wrreq  = 1'b0;
            bus.master_rdreq = 1'b0;
            step();
        end
        chk("spur_done", 32'(done_pulses), 32'(dp));
        chk("spur_busy", 32'(bus.busy), 32'd0);
        chk("spur_empty", 32'(bus.master_empty), 32'd1);
        set_cmd(0, 1'b1, 7'h7F, 16'h0000);
        bus.req = 2'b01;
        grant(0, 8'h11, 8'h22, 8'h33, 0);
        bus.req = '0;
        serve(3);
        finish_done(20, n);
        chk("spur_read_latency", 32'(n), 32'd1);

        // Timeout after the first byte, then a normal frame
        set_cmd(1, 1'b0, 7'h2A, 16'h1234);
        bus.req = 2'b10;
        grant(1, 8'h44, 8'h55, 8'h66, 1);
        bus.req = '0;
        serve(1);
        finish_done(TIMEOUT + 50, n);
        chk("timeout_window", 32'(n >= TIMEOUT && n <= TIMEOUT + 2), 32'd1);
        exp_tx_q.delete();
        miso_q.delete();
        set_cmd(0, 1'b0, 7'h15, 16'hA55A);
        bus.req = 2'b01;
        grant(0, 8'h0F, 8'hF0, 8'h3C, 0);
        bus.req = '0;
        serve(3);
        finish_done(20, n);
        chk("post_timeout_latency", 32'(n), 32'd1);

        // Reset asserted after the second byte has been consumed
        set_cmd(0, 1'b0, 7'h44, 16'hBEEF);
        bus.req = 2'b01;
        grant(0, 8'h12, 8'h34, 8'h56, 2);
        bus.req = '0;
        serve(2);
        dp = done_pulses;
        n_rst = 1'b0;
        #1;
        chk("abort_empty", 32'(bus.master_empty), 32'd1);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        exp_tx_q.delete();
        miso_q.delete();
        model_rdata = '0;
        bus.req = 2'b11;
        repeat (3) step();
        chk("abort_ack_in_reset", 32'(bus.ack), 32'd0);
        n_rst = 1'b1;
        grant(0, 8'hA1, 8'hB2, 8'hC3, 0);
        bus.req = '0;
        serve(3);
        finish_done(20, n);
        chk("abort_no_stray_done", 32'(done_pulses), 32'(dp + 1));
        chk("final_no_overlap", 32'(overlap_cycles), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
